// File: rtl/onehot_to_binary_pipe_pkg.sv
// +--------------------------------------------------------------------------+
// | onehot_pkg: shared widths, stage types and lowest-set-bit helper.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package onehot_pkg;

  localparam int BIN_W_DEF     = 4;
  localparam int ONE_HOT_W_DEF = 16;
  localparam int CNT_W_DEF     = 8;

  // lsb_index works on the widest supported word; narrower words are zero-extended
  localparam int LSB_MAX_W = 64;
  localparam int LSB_IDX_W = 6;

  typedef struct packed {
    logic [ONE_HOT_W_DEF-1:0] one_hot;
    logic                     zero;
    logic                     multi;
  } s1_t;

  typedef struct packed {
    logic [BIN_W_DEF-1:0] bin;
    logic                 err;
  } s2_t;

  function automatic logic [LSB_IDX_W-1:0] lsb_index(input logic [LSB_MAX_W-1:0] word);
    logic [LSB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = LSB_MAX_W - 1; i >= 0; i--) begin
      if (word[i]) idx = LSB_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_to_binary_pipe_if.sv
// +--------------------------------------------------------------------------+
// | onehot_to_binary_pipe_if: input/output valid-ready streams of converter. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface onehot_to_binary_pipe_if
  import onehot_pkg::*;
#(
  parameter int BIN_W     = BIN_W_DEF,
  parameter int ONE_HOT_W = ONE_HOT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
);

  logic [ONE_HOT_W-1:0] one_hot_i;
  logic                 valid_i;
  logic                 ready_o;
  logic [BIN_W-1:0]     bin_o;
  logic                 err_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [CNT_W-1:0]     err_cnt_o;

  modport master (
    output one_hot_i, valid_i, ready_i,
    input  ready_o, bin_o, err_o, valid_o, err_cnt_o
  );

  modport slave (
    input  one_hot_i, valid_i, ready_i,
    output ready_o, bin_o, err_o, valid_o, err_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/onehot_to_binary_pipe_check.sv
// +--------------------------------------------------------------------------+
// | onehot_check: combinational zero / multi-hot detector.                   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module onehot_check
  import onehot_pkg::*;
#(
  parameter int W = ONE_HOT_W_DEF
) (
  input  logic [W-1:0] word_i,
  output logic         zero_o,
  output logic         multi_o
);

  assign zero_o  = (word_i == '0);
  // clearing the lowest set bit leaves something only when two or more were set
  assign multi_o = |(word_i & (word_i - W'(1)));

endmodule

`default_nettype wire

// File: rtl/onehot_to_binary_pipe.sv
// +--------------------------------------------------------------------------+
// | onehot_to_binary_pipe: 2-stage elastic one-hot to binary converter.      |
// | Optional saturating error counter enabled by ONEHOT_ERR_CNT_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module onehot_to_binary_pipe
  import onehot_pkg::*;
#(
  parameter int BIN_W     = BIN_W_DEF,
  parameter int ONE_HOT_W = ONE_HOT_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  onehot_to_binary_pipe_if.slave  bus
);

  if (ONE_HOT_W != 2 ** BIN_W) begin : g_bad_width
    $error("onehot_to_binary_pipe: ONE_HOT_W must equal 2**BIN_W");
  end
  if (ONE_HOT_W > LSB_MAX_W) begin : g_too_wide
    $error("onehot_to_binary_pipe: ONE_HOT_W exceeds lsb_index range");
  end

  typedef struct packed {
    logic [ONE_HOT_W-1:0] one_hot;
    logic                 zero;
    logic                 multi;
  } stage1_t;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             err;
  } stage2_t;

  stage1_t s1_q, s1_d;
  stage2_t s2_q, s2_d;
  logic    s1_valid_q, s1_valid_d;
  logic    s2_valid_q, s2_valid_d;

  logic w_s1_ready, w_s2_ready, w_in_xfer, w_s1_move;
  logic w_zero, w_multi;

  onehot_check #(.W(ONE_HOT_W)) u_check (
    .word_i  (bus.one_hot_i),
    .zero_o  (w_zero),
    .multi_o (w_multi)
  );

  always_comb begin
    w_s2_ready = !s2_valid_q || bus.ready_i;
    w_s1_ready = !s1_valid_q || w_s2_ready;
    w_in_xfer  = bus.valid_i && w_s1_ready;
    w_s1_move  = s1_valid_q && w_s2_ready;

    s1_valid_d = w_in_xfer || (s1_valid_q && !w_s2_ready);
    s1_d       = s1_q;
    if (w_in_xfer) begin
      s1_d.one_hot = bus.one_hot_i;
      s1_d.zero    = w_zero;
      s1_d.multi   = w_multi;
    end

    s2_valid_d = w_s1_move || (s2_valid_q && !bus.ready_i);
    s2_d       = s2_q;
    if (w_s1_move) begin
      s2_d.bin = BIN_W'(lsb_index(LSB_MAX_W'(s1_q.one_hot)));
      s2_d.err = s1_q.zero || s1_q.multi;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.ready_o = w_s1_ready;
  assign bus.valid_o = s2_valid_q;
  assign bus.bin_o   = s2_q.bin;
  assign bus.err_o   = s2_q.err;

`ifdef ONEHOT_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && bus.ready_i && s2_q.err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt_o = err_cnt_q;
`else
  assign bus.err_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_onehot_to_binary_pipe.sv
// +--------------------------------------------------------------------------+
// | tb_onehot_to_binary_pipe: directed self-checking bench for the converter.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_onehot_to_binary_pipe;
  import onehot_pkg::*;

`ifdef ONEHOT_ERR_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  onehot_to_binary_pipe_if #(.BIN_W(4), .ONE_HOT_W(16), .CNT_W(CNT_W)) bus ();

  onehot_to_binary_pipe #(.BIN_W(4), .ONE_HOT_W(16), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  s2_t  exp_q[$];
  int   out_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output scoreboard: every delivered word must match the next hand-computed entry
  always @(negedge clk) begin
    if (rst_n && bus.valid_o && bus.ready_i) begin
      s2_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(bus.valid_o), 0);
      end else begin
        e = exp_q.pop_front();
        chk("bin_o", 32'(bus.bin_o), 32'(e.bin));
        chk("err_o", 32'(bus.err_o), 32'(e.err));
      end
      out_cyc_q.push_back(cyc);
    end
  end

  task automatic drive(input logic [15:0] w, input bit push, input logic [3:0] b, input logic e);
    bus.one_hot_i = w;
    bus.valid_i   = 1'b1;
    if (push) exp_q.push_back('{bin: b, err: e});
  endtask

  task automatic wait_acc(output int acc);
    bit r;
    int n;
    n   = 0;
    acc = -1;
    forever begin
      @(negedge clk);
      r = bus.ready_o;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
      n++;
      if (n > 30) begin
        chk("accept_timeout", 32'(n), 0);
        break;
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic send(input logic [15:0] w, input logic [3:0] b, input logic e, output int acc);
    drive(w, 1'b1, b, e);
    wait_acc(acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc0;
    int exp_cnt[5];
`ifdef ONEHOT_ERR_CNT_EN
    exp_cnt = '{1, 2, 3, 3, 3};
`else
    exp_cnt = '{0, 0, 0, 0, 0};
`endif

    bus.one_hot_i = 16'h0001;
    bus.valid_i   = 1'b1;
    bus.ready_i   = 1'b1;
    rst_n         = 1'b0;

    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid_o", 32'(bus.valid_o), 0);
      chk("rst_bin_o", 32'(bus.bin_o), 0);
      chk("rst_err_o", 32'(bus.err_o), 0);
      chk("rst_err_cnt", 32'(bus.err_cnt_o), 0);
    end
    rst_n       = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready_o", 32'(bus.ready_o), 1);
    chk("post_rst_valid_o", 32'(bus.valid_o), 0);
    @(posedge clk);
    #1;

    // Sweep: each single-bit word decodes to its bit position, one per cycle
    out_cyc_q.delete();
    acc0 = 0;
    for (int k = 0; k < 16; k++) begin
      send(16'(1) << k, 4'(k), 1'b0, acc);
      if (k == 0) acc0 = acc;
    end
    drain();
    chk("sweep_count", 32'(out_cyc_q.size()), 16);
    if (out_cyc_q.size() >= 16) begin
      chk("sweep_latency", 32'(out_cyc_q[0] - acc0), 1);
      chk("sweep_rate", 32'(out_cyc_q[15] - out_cyc_q[0]), 15);
    end

    // Error words and boundary indices
    send(16'h0000, 4'd0, 1'b1, acc);
    send(16'h0014, 4'd2, 1'b1, acc);
    send(16'h8000, 4'd15, 1'b0, acc);
    send(16'h0001, 4'd0, 1'b0, acc);
    send(16'hFFFF, 4'd0, 1'b1, acc);
    drain();

    // Backpressure: two words fill the pipe, the third waits
    bus.ready_i = 1'b0;
    send(16'h0008, 4'd3, 1'b0, acc);
    send(16'h0080, 4'd7, 1'b0, acc);
    drive(16'h0000, 1'b1, 4'd0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready_o", 32'(bus.ready_o), 0);
      chk("bp_valid_o", 32'(bus.valid_o), 1);
      chk("bp_bin_hold", 32'(bus.bin_o), 3);
      chk("bp_err_hold", 32'(bus.err_o), 0);
      @(posedge clk);
      #1;
    end
    bus.ready_i = 1'b1;
    wait_acc(acc);
    send(16'h1000, 4'd12, 1'b0, acc);
    send(16'h0300, 4'd8, 1'b1, acc);
    drain();

    // Mid-flight reset: two in-flight words must vanish
    bus.ready_i = 1'b0;
    drive(16'h0020, 1'b0, 4'd0, 1'b0);
    wait_acc(acc);
    drive(16'h0200, 1'b0, 4'd0, 1'b0);
    wait_acc(acc);
    @(negedge clk);
    chk("pre_flush_valid_o", 32'(bus.valid_o), 1);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_valid_o", 32'(bus.valid_o), 0);
    end
    chk("flush_err_cnt", 32'(bus.err_cnt_o), 0);
    @(posedge clk);
    #1;

    // Error counter: saturates in the counting build, stays zero otherwise
    for (int i = 0; i < 5; i++) begin
      send(16'h0000, 4'd0, 1'b1, acc);
      drain();
      @(negedge clk);
      chk("err_cnt", 32'(bus.err_cnt_o), 32'(exp_cnt[i]));
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
